// File: rtl/block_ctrl_pkg.sv
// Shared encodings for the block display command path: action codes, field
// positions, the sequencer state enum and the queued request layout.
package block_ctrl_pkg;

  localparam logic [3:0] ACT_NOP    = 4'b0000;
  localparam logic [3:0] ACT_UPDATE = 4'b0001;
  localparam logic [3:0] ACT_SWAP   = 4'b1111;

  localparam logic [2:0] TYPE_NONE = 3'b000;
  localparam logic [2:0] TYPE_PAT  = 3'b001;
  localparam logic [2:0] TYPE_XPOS = 3'b010;
  localparam logic [2:0] TYPE_YPOS = 3'b011;

  localparam int COMP_LSB   = 26;
  localparam int CHILD_LSB  = 21;
  localparam int ACT_LSB    = 17;
  localparam int TYPE_LSB   = 14;
  localparam int TOGGLE_BIT = 13;
  localparam int DATA_W     = 13;
  localparam int VIS_BIT    = 12;
  localparam int FLIP_BIT   = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAT,
    ST_XPOS,
    ST_YPOS,
    ST_SWAP
  } state_e;

  typedef struct packed {
    logic [4:0] child;
    logic       visible;
    logic       flip;
    logic [4:0] pattern;
    logic [9:0] x;
    logic [9:0] y;
  } req_t;

  function automatic logic [31:0] cmd_word(input logic [5:0]        comp,
                                           input logic [4:0]        child,
                                           input logic [3:0]        act,
                                           input logic [2:0]        atype,
                                           input logic              toggle,
                                           input logic [DATA_W-1:0] data);
    logic [31:0] w;
    w                   = '0;
    w[COMP_LSB +: 6]    = comp;
    w[CHILD_LSB +: 5]   = child;
    w[ACT_LSB +: 4]     = act;
    w[TYPE_LSB +: 3]    = atype;
    w[TOGGLE_BIT]       = toggle;
    w[DATA_W-1:0]       = data;
    return w;
  endfunction

endpackage

// File: rtl/req_fifo.sv
// Single-clock request queue with full/empty flags; head is visible
// combinationally so the consumer can inspect it before popping.
module req_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/block_cmd_sequencer.sv
// Turns queued sprite updates into PAT/XPOS/YPOS command words and issues a
// double-buffer swap at the configured raster line when anything changed.
module block_cmd_sequencer
  import block_ctrl_pkg::*;
#(
  parameter logic [5:0] COMPONENT_ID = 6'b000010,
  parameter int         MAX_CHILD    = 9,
  parameter int         MAX_PATTERN  = 17,
  parameter int         FIFO_DEPTH   = 4,
  parameter int         SWAP_LINE    = 480
) (
  input  logic        clk,
  input  logic        reset,
  // req_valid/req_ready: a request transfers on a rising edge where both are
  // high; the requester holds valid and payload stable until then, and
  // req_ready is simply the queue's not-full flag.
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_child,
  input  logic        req_visible,
  input  logic        req_flip,
  input  logic [4:0]  req_pattern,
  input  logic [9:0]  req_x,
  input  logic [9:0]  req_y,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [31:0] writedata,
  output logic        back_buf,
  output logic        frame_done,
  output logic        err,
  output state_e      dbg_state
);

  req_t   push_data;
  req_t   head;
  req_t   cur;
  state_e state;
  logic   fifo_full;
  logic   fifo_empty;
  logic   pop;
  logic   head_ok;
  logic   swap_trig;
  logic   trig_q;
  logic   swap_pending;
  logic   dirty;
  logic [DATA_W-1:0] pat_data;

  assign push_data = {req_child, req_visible, req_flip, req_pattern, req_x, req_y};
  assign req_ready = !fifo_full;
  assign dbg_state = state;
  assign swap_trig = (vcount == 10'(SWAP_LINE)) && (hcount == '0);
  assign head_ok   = (int'(head.child) < MAX_CHILD) && (int'(head.pattern) < MAX_PATTERN);
  // A pending swap blocks popping so a request never straddles the swap.
  assign pop       = (state == ST_IDLE) && !swap_pending && !fifo_empty;

  req_fifo #(
    .WIDTH ($bits(req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_valid),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      cur          <= '0;
      back_buf     <= 1'b1;
      swap_pending <= 1'b0;
      dirty        <= 1'b0;
      frame_done   <= 1'b0;
      err          <= 1'b0;
      trig_q       <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      err        <= 1'b0;
      trig_q     <= swap_trig;
      case (state)
        ST_IDLE: begin
          if (swap_pending) begin
            if (dirty) state <= ST_SWAP;
            else       swap_pending <= 1'b0;
          end else if (!fifo_empty) begin
            if (head_ok) begin
              cur   <= head;
              state <= ST_PAT;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_PAT:  state <= ST_XPOS;
        ST_XPOS: state <= ST_YPOS;
        ST_YPOS: begin
          state <= ST_IDLE;
          dirty <= 1'b1;
        end
        ST_SWAP: begin
          state        <= ST_IDLE;
          back_buf     <= ~back_buf;
          dirty        <= 1'b0;
          swap_pending <= 1'b0;
          frame_done   <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
      // A fresh raster trigger wins over a same-cycle clear: it is a new frame.
      if (swap_trig && !trig_q) swap_pending <= 1'b1;
    end
  end

  always_comb begin
    pat_data           = '0;
    pat_data[VIS_BIT]  = cur.visible;
    pat_data[FLIP_BIT] = cur.flip;
    pat_data[4:0]      = cur.pattern;
  end

  always_comb begin
    writedata = '0;
    case (state)
      ST_PAT:  writedata = cmd_word(COMPONENT_ID, cur.child, ACT_UPDATE, TYPE_PAT, back_buf, pat_data);
      ST_XPOS: writedata = cmd_word(COMPONENT_ID, cur.child, ACT_UPDATE, TYPE_XPOS, back_buf, {3'b000, cur.x});
      ST_YPOS: writedata = cmd_word(COMPONENT_ID, cur.child, ACT_UPDATE, TYPE_YPOS, back_buf, {3'b000, cur.y});
      ST_SWAP: writedata = cmd_word(COMPONENT_ID, 5'd0, ACT_SWAP, TYPE_NONE, back_buf, '0);
      default: writedata = '0;
    endcase
  end

endmodule

// File: tb/tb_block_cmd_sequencer.sv
// Bench for block_cmd_sequencer: directed scenarios with literal words plus a
// randomized phase, all checked every cycle against a word-level model.
module tb_block_cmd_sequencer;

  localparam logic [5:0] COMP        = 6'b000010;
  localparam int         MAX_CHILD   = 9;
  localparam int         MAX_PATTERN = 17;
  localparam int         FIFO_DEPTH  = 4;
  localparam int         SWAP_LINE   = 480;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_child = '0;
  logic        req_visible = 1'b0;
  logic        req_flip = 1'b0;
  logic [4:0]  req_pattern = '0;
  logic [9:0]  req_x = '0;
  logic [9:0]  req_y = '0;
  logic [9:0]  hcount = 10'd1;
  logic [9:0]  vcount = '0;
  logic [31:0] writedata;
  logic        back_buf;
  logic        frame_done;
  logic        err;
  block_ctrl_pkg::state_e dbg_state;

  always #5 clk = ~clk;

  block_cmd_sequencer #(
    .COMPONENT_ID (COMP),
    .MAX_CHILD    (MAX_CHILD),
    .MAX_PATTERN  (MAX_PATTERN),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .SWAP_LINE    (SWAP_LINE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_child   (req_child),
    .req_visible (req_visible),
    .req_flip    (req_flip),
    .req_pattern (req_pattern),
    .req_x       (req_x),
    .req_y       (req_y),
    .hcount      (hcount),
    .vcount      (vcount),
    .writedata   (writedata),
    .back_buf    (back_buf),
    .frame_done  (frame_done),
    .err         (err),
    .dbg_state   (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Requests sit in mq; once a request starts, its remaining words wait in
  // exp_q and come out one per cycle. exp_wd is the word for the current cycle.
  typedef struct {
    logic [4:0] child;
    logic       vis;
    logic       flip;
    logic [4:0] pat;
    logic [9:0] x;
    logic [9:0] y;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_wd = '0;
  logic        exp_bb = 1'b1;
  logic        exp_fd = 1'b0;
  logic        exp_err = 1'b0;
  logic        m_pending = 1'b0;
  logic        m_dirty = 1'b0;
  logic        m_trig_prev = 1'b0;
  logic        m_was_idle, m_take, m_trig;
  mreq_t       m_in, m_hd;

  function automatic logic [31:0] word(input logic [4:0] child, input logic [3:0] act,
                                       input logic [2:0] typ, input logic tog,
                                       input logic [12:0] data);
    return {COMP, child, act, typ, tog, data};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      exp_q.delete();
      exp_wd      = '0;
      exp_bb      = 1'b1;
      exp_fd      = 1'b0;
      exp_err     = 1'b0;
      m_pending   = 1'b0;
      m_dirty     = 1'b0;
      m_trig_prev = 1'b0;
    end else begin
      m_take     = req_valid && (mq.size() < FIFO_DEPTH);
      m_trig     = (vcount == 10'(SWAP_LINE)) && (hcount == 10'd0);
      m_in       = '{req_child, req_visible, req_flip, req_pattern, req_x, req_y};
      m_was_idle = (exp_wd == 32'h0);
      exp_fd     = 1'b0;
      exp_err    = 1'b0;
      if (exp_wd[20:17] == 4'b0001 && exp_wd[16:14] == 3'b011) m_dirty = 1'b1;
      if (exp_wd[20:17] == 4'b1111) begin
        exp_bb    = ~exp_bb;
        m_dirty   = 1'b0;
        m_pending = 1'b0;
        exp_fd    = 1'b1;
      end
      if (exp_q.size() > 0) begin
        exp_wd = exp_q.pop_front();
      end else if (!m_was_idle) begin
        exp_wd = '0;
      end else if (m_pending) begin
        if (m_dirty) exp_wd = word(5'd0, 4'b1111, 3'b000, exp_bb, 13'd0);
        else begin
          m_pending = 1'b0;
          exp_wd    = '0;
        end
      end else if (mq.size() > 0) begin
        m_hd = mq.pop_front();
        if (m_hd.child >= MAX_CHILD || m_hd.pat >= MAX_PATTERN) begin
          exp_err = 1'b1;
          exp_wd  = '0;
        end else begin
          exp_wd = word(m_hd.child, 4'b0001, 3'b001, exp_bb, {m_hd.vis, m_hd.flip, 6'd0, m_hd.pat});
          exp_q.push_back(word(m_hd.child, 4'b0001, 3'b010, exp_bb, {3'd0, m_hd.x}));
          exp_q.push_back(word(m_hd.child, 4'b0001, 3'b011, exp_bb, {3'd0, m_hd.y}));
        end
      end else begin
        exp_wd = '0;
      end
      if (m_trig && !m_trig_prev) m_pending = 1'b1;
      m_trig_prev = m_trig;
      if (m_take) mq.push_back(m_in);
    end
  end

  // ---------------- scoreboard compare + event counters ----------------
  int n_upd_words = 0;
  int n_swap_words = 0;
  int n_err = 0;

  always @(negedge clk) begin
    check("writedata", writedata, exp_wd);
    check("back_buf", back_buf, exp_bb);
    check("frame_done", frame_done, exp_fd);
    check("err", err, exp_err);
    check("req_ready", req_ready, mq.size() < FIFO_DEPTH);
    if (writedata[20:17] == 4'b0001) n_upd_words++;
    if (writedata[20:17] == 4'b1111) n_swap_words++;
    if (err) n_err++;
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after acceptance, valid left high.
  task automatic push_req(input logic [4:0] c, input logic v, input logic f,
                          input logic [4:0] p, input logic [9:0] x, input logic [9:0] y);
    int guard = 0;
    req_valid   = 1'b1;
    req_child   = c;
    req_visible = v;
    req_flip    = f;
    req_pattern = p;
    req_x       = x;
    req_y       = y;
    while (!req_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: req_ready stayed 0 for %0d cycles, required 1", guard);
    end
    @(negedge clk);
  endtask

  task automatic swap_line();
    vcount = 10'(SWAP_LINE);
    hcount = 10'd0;
    @(negedge clk);
    vcount = 10'd0;
    hcount = 10'd1;
  endtask

  task automatic expect_wd(input string name, input logic [31:0] exp);
    @(negedge clk);
    check(name, writedata, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int   u0, s0, e0, trig_left;
    logic rdy_seen;

    repeat (3) @(negedge clk);
    check("rst_writedata", writedata, 32'h0);
    check("rst_back_buf", back_buf, 1'b1);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_state", dbg_state, block_ctrl_pkg::ST_IDLE);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", req_ready, 1'b1);

    // Single update: three words with fixed latency, then idle.
    push_req(5'd3, 1'b1, 1'b0, 5'd5, 10'd100, 10'd200);
    req_valid = 1'b0;
    check("latency_idle", writedata, 32'h0);
    expect_wd("pat_word", 32'h08627005);
    expect_wd("xpos_word", 32'h0862A064);
    expect_wd("ypos_word", 32'h0862E0C8);
    expect_wd("after_request", 32'h0);

    // Swap after an update.
    swap_line();
    expect_wd("swap_word", 32'h081E2000);
    @(negedge clk);
    check("back_buf_after_swap", back_buf, 1'b0);
    check("frame_done_pulse", frame_done, 1'b1);
    check("idle_after_swap", writedata, 32'h0);
    @(negedge clk);
    check("frame_done_single", frame_done, 1'b0);

    // Swap line with nothing changed: no swap word, buffer kept.
    s0 = n_swap_words;
    swap_line();
    repeat (4) @(negedge clk);
    check("clean_no_swap_word", n_swap_words - s0, 0);
    check("clean_back_buf_kept", back_buf, 1'b0);

    // Out-of-range child and pattern are dropped with one err pulse each.
    e0 = n_err;
    u0 = n_upd_words;
    push_req(5'd9, 1'b1, 1'b1, 5'd3, 10'd10, 10'd20);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("bad_child_err", n_err - e0, 1);
    check("bad_child_no_words", n_upd_words - u0, 0);
    e0 = n_err;
    push_req(5'd2, 1'b0, 1'b0, 5'd20, 10'd10, 10'd20);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("bad_pattern_err", n_err - e0, 1);
    check("bad_pattern_no_words", n_upd_words - u0, 0);
    push_req(5'd8, 1'b0, 1'b1, 5'd16, 10'd1023, 10'd0);
    req_valid = 1'b0;
    expect_wd("edge_pat_word", 32'h09024810);
    expect_wd("edge_xpos_word", 32'h090283FF);
    expect_wd("edge_ypos_word", 32'h0902C000);

    // Swap arrives mid-request while five more updates queue up behind it.
    repeat (2) @(negedge clk);
    u0 = n_upd_words;
    s0 = n_swap_words;
    push_req(5'd1, 1'b1, 1'b0, 5'd2, 10'd11, 10'd22);
    vcount = 10'(SWAP_LINE);
    hcount = 10'd0;
    push_req(5'd2, 1'b1, 1'b1, 5'd3, 10'd12, 10'd23);
    vcount = 10'd0;
    hcount = 10'd1;
    push_req(5'd4, 1'b0, 1'b0, 5'd4, 10'd13, 10'd24);
    push_req(5'd5, 1'b1, 1'b0, 5'd6, 10'd14, 10'd25);
    push_req(5'd6, 1'b0, 1'b1, 5'd7, 10'd15, 10'd26);
    check("ready_low_when_full", req_ready, 1'b0);
    push_req(5'd7, 1'b1, 1'b1, 5'd8, 10'd16, 10'd27);
    req_valid = 1'b0;
    repeat (30) @(negedge clk);
    check("burst_update_words", n_upd_words - u0, 18);
    check("burst_swap_words", n_swap_words - s0, 1);
    check("burst_back_buf", back_buf, 1'b1);

    // Reset while XPOS is on the bus, with a second request still queued.
    push_req(5'd4, 1'b1, 1'b1, 5'd7, 10'd300, 10'd400);
    push_req(5'd5, 1'b0, 1'b0, 5'd1, 10'd5, 10'd6);
    req_valid = 1'b0;
    expect_wd("xpos_before_reset", 32'h0882A12C);
    #2;
    reset = 1'b0;
    #1;
    check("reset_writedata", writedata, 32'h0);
    check("reset_back_buf", back_buf, 1'b1);
    check("reset_ready", req_ready, 1'b1);
    check("reset_state", dbg_state, block_ctrl_pkg::ST_IDLE);
    @(negedge clk);
    reset = 1'b1;
    u0 = n_upd_words;
    repeat (8) @(negedge clk);
    check("reset_fifo_flushed", n_upd_words - u0, 0);

    // Randomized traffic with occasional (sometimes held) swap triggers.
    rdy_seen  = 1'b1;
    trig_left = 0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      @(negedge clk);
      if (!(req_valid && !rdy_seen)) begin
        req_valid   = ($urandom_range(0, 99) < 40);
        req_child   = 5'($urandom_range(0, 10));
        req_visible = 1'($urandom_range(0, 1));
        req_flip    = 1'($urandom_range(0, 1));
        req_pattern = 5'($urandom_range(0, 19));
        req_x       = 10'($urandom_range(0, 1023));
        req_y       = 10'($urandom_range(0, 1023));
      end
      rdy_seen = req_ready;
      if (trig_left == 0 && $urandom_range(0, 39) == 0) trig_left = $urandom_range(1, 3);
      if (trig_left > 0) begin
        vcount = 10'(SWAP_LINE);
        hcount = 10'd0;
        trig_left--;
      end else begin
        vcount = 10'($urandom_range(0, 524));
        hcount = 10'($urandom_range(1, 799));
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    vcount    = 10'd0;
    hcount    = 10'd1;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/block_cmd_sequencer.md
BLOCK_CMD_SEQUENCER -- requirements
Module: block_cmd_sequencer

Interface
REQ-001 The block SHALL have parameter COMPONENT_ID, default 6'b000010: component field placed in every command word.
REQ-002 The block SHALL have parameter MAX_CHILD, default 9: number of legal child sprite slots.
REQ-003 The block SHALL have parameter MAX_PATTERN, default 17: number of legal pattern indices.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4: depth of the request queue.
REQ-005 The block SHALL have parameter SWAP_LINE, default 480: vcount value that marks the buffer-swap point.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port req_valid, input, 1 bit: the requester offers a sprite update.
REQ-009 The block SHALL have port req_ready, output, 1 bit: the queue accepts the update.
REQ-010 The block SHALL have port req_child, input, 5 bits: target child slot.
REQ-011 The block SHALL have ports req_visible and req_flip, input, 1 bit each: visibility and flip flags.
REQ-012 The block SHALL have port req_pattern, input, 5 bits: pattern index.
REQ-013 The block SHALL have ports req_x and req_y, input, 10 bits each: sprite position.
REQ-014 The block SHALL have ports hcount and vcount, input, 10 bits each: raster position.
REQ-015 The block SHALL have port writedata, output, 32 bits: command word to the block display.
REQ-016 The block SHALL have port back_buf, output, 1 bit: index of the buffer currently being written.
REQ-017 The block SHALL have ports frame_done and err, output, 1 bit each: one-cycle pulses.

Function
REQ-018 The command word SHALL use this layout: [31:26] component, [25:21] child, [20:17] action, [16:14] action_type, [13] buffer toggle, [12:0] data.
REQ-019 A handshake SHALL occur when req_valid and req_ready are both high on a rising edge; req_ready SHALL equal not-full.
REQ-020 A push and a pop in the same cycle SHALL leave the occupancy unchanged.
REQ-021 The FSM SHALL have the states IDLE, PAT, XPOS, YPOS and SWAP, and writedata SHALL be decoded only from registered state.
REQ-022 In IDLE, swap_pending SHALL take priority over a non-empty FIFO.
REQ-023 Otherwise IDLE SHALL pop the head, register its fields and go to PAT.
REQ-024 A popped request with child >= MAX_CHILD or pattern >= MAX_PATTERN SHALL be dropped: err pulses 1 cycle, no words are issued, and the FSM stays in IDLE.
REQ-025 PAT SHALL drive action 4'b0001, type 3'b001, toggle = back_buf, data[12] = visible, data[11] = flip, data[4:0] = pattern, other data bits 0.
REQ-026 XPOS SHALL drive type 3'b010 with data[9:0] = x, and YPOS SHALL drive type 3'b011 with data[9:0] = y.
REQ-027 Each state SHALL last exactly 1 cycle, after which YPOS returns to IDLE and sets dirty.
REQ-028 Latency: a request pushed at edge E into an empty FIFO with the FSM idle SHALL give PAT after E+1, XPOS after E+2, YPOS after E+3, and 0 after E+4.
REQ-029 In IDLE, and in every cycle not otherwise defined, writedata SHALL be 32'h0 (no-op).
REQ-030 swap_pending SHALL set on the first cycle where vcount == SWAP_LINE and hcount == 0; a repeated trigger while pending SHALL NOT double-count.
REQ-031 In IDLE with swap_pending and dirty set, the FSM SHALL enter SWAP for 1 cycle: action 4'b1111, toggle = back_buf, child 0, data 0.
REQ-032 On leaving SWAP, back_buf SHALL invert, dirty and swap_pending SHALL clear, and frame_done SHALL pulse.
REQ-033 In IDLE with swap_pending set and dirty clear, swap_pending SHALL clear with no command issued, so the sprites on screen are never blanked.
REQ-034 A swap trigger arriving mid-request SHALL wait until YPOS completes; a request's three words SHALL never straddle a swap.

Reset
REQ-035 Reset assertion SHALL immediately force state IDLE, FIFO empty, writedata 32'h0, back_buf 1, swap_pending 0, dirty 0, frame_done 0 and err 0.
REQ-036 req_ready SHALL be 1 after reset release.
REQ-037 A request in flight SHALL be discarded without completing its words.

Structure
REQ-038 Package block_ctrl_pkg SHALL hold the action codes (NOP 4'b0000, UPDATE 4'b0001, SWAP 4'b1111), the action_type codes, the field bit positions and the FSM state enum.
REQ-039 The request queue SHALL be a sub-module named req_fifo: synchronous, parameterised on width and depth, with full/empty flags.

Verification
REQ-040 After reset, push child 3, visible 1, flip 0, pattern 5, x 100, y 200 -> writedata 0x08627005, 0x0862A064, 0x0862E0C8 on consecutive cycles, then 0x00000000.
REQ-041 After REQ-040, drive vcount 480 with hcount 0 -> one cycle of 0x081E2000, then back_buf = 0 and frame_done pulses once.
REQ-042 Drive the swap line with no update since the last swap -> no 1111 word, back_buf unchanged.
REQ-043 Push 5 back-to-back requests while the swap is pending -> req_ready low after 4 accepted, all 15 words issued in order after the SWAP word, no loss.
REQ-044 Push child 9, or pattern 20 -> err pulses once, writedata stays 0, and the next valid request is issued normally.
REQ-045 Assert reset during XPOS -> writedata 0 immediately, FIFO empty, back_buf 1.
